// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: pulls 64-bit words from the async FIFO read port and
// streams each one as an 11-byte frame (2 header, 8 data MSB first, XOR sum).
//
// Ports:
//   rd_clk       in   FIFO read clock, the only clock of this block
//   rst_n        in   synchronous active-low reset
//   pack_en      in   allows new frames to start (sampled in IDLE only)
//   fifo_rd_en   out  one-cycle read pulse to the FIFO
//   fifo_dout    in   FIFO read data (registered port)
//   fifo_vld     in   FIFO read data valid
//   tx_data      out  byte to the transmitter
//   tx_valid     out  tx_data valid
//   tx_ready     in   transmitter accepts the byte this cycle
//   busy         out  high whenever the FSM is not in IDLE
//   frame_cnt    out  completed frame counter, wraps
//   late_vld_err out  sticky flag: fifo_vld seen outside the capture window
module fifo_frame_packer #(
   parameter logic [7:0]  HDR0       = 8'hA5,
   parameter logic [7:0]  HDR1       = 8'h5A,
   parameter int unsigned RD_TIMEOUT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             rd_clk,
   input  logic             rst_n,
   input  logic             pack_en,
   output logic             fifo_rd_en,
   input  logic [63:0]      fifo_dout,
   input  logic             fifo_vld,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             late_vld_err
);

   localparam int TO_W = $clog2(RD_TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM
   } state_t;

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic [63:0]     word;
   logic [7:0]      csum;
   logic [2:0]      idx;

   // The word register shifts left by one byte per accepted data byte,
   // so the next byte to present is always word[55:48].
   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         to_cnt       <= '0;
         word         <= '0;
         csum         <= '0;
         idx          <= '0;
         fifo_rd_en   <= 1'b0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         busy         <= 1'b0;
         frame_cnt    <= '0;
         late_vld_err <= 1'b0;
      end else begin
         if (fifo_vld && state != S_WAIT)
            late_vld_err <= 1'b1;

         unique case (state)
            S_IDLE: begin
               if (pack_en) begin
                  state      <= S_REQ;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            S_REQ: begin
               fifo_rd_en <= 1'b0;
               to_cnt     <= '0;
               state      <= S_WAIT;
            end

            S_WAIT: begin
               // A valid word beats a timeout on the same cycle.
               if (fifo_vld) begin
                  word     <= fifo_dout;
                  csum     <= '0;
                  tx_data  <= HDR0;
                  tx_valid <= 1'b1;
                  state    <= S_HDR0;
               end else if (to_cnt == TO_LAST) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            S_HDR0: begin
               if (tx_ready) begin
                  tx_data <= HDR1;
                  state   <= S_HDR1;
               end
            end

            S_HDR1: begin
               if (tx_ready) begin
                  tx_data <= word[63:56];
                  idx     <= '0;
                  state   <= S_DATA;
               end
            end

            S_DATA: begin
               if (tx_ready) begin
                  csum <= csum ^ tx_data;
                  if (idx == 3'd7) begin
                     tx_data <= csum ^ tx_data;
                     state   <= S_CSUM;
                  end else begin
                     tx_data <= word[55:48];
                     word    <= {word[55:0], 8'h00};
                     idx     <= idx + 1'b1;
                  end
               end
            end

            S_CSUM: begin
               if (tx_ready) begin
                  tx_valid  <= 1'b0;
                  frame_cnt <= frame_cnt + CNT_W'(1);
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
- Downstream consumer of the 8-in/64-out async FIFO. Runs entirely in the FIFO read-clock domain.
- Pulls one 64-bit word at a time using the FIFO's registered read port (rd_en in; rd_dout and rd_out_vld out).
- Wraps each word in a byte frame: 2 header bytes, 8 data bytes MSB first, 1 XOR checksum byte.
- Streams the frame to a byte-wide transmitter (UART TX) over a valid/ready handshake.

Parameters:
- HDR0, 8'hA5, first header byte.
- HDR1, 8'h5A, second header byte.
- RD_TIMEOUT, 4, cycles to wait for fifo_vld after a read pulse before declaring the FIFO empty (min 2).
- CNT_W, 16, width of frame_cnt.

Ports:
- rd_clk  in  1  block clock (FIFO read clock)
- rst_n  in  1  synchronous active-low reset
- pack_en  in  1  enables starting new frames
- fifo_rd_en  out  1  read pulse to FIFO rd_en
- fifo_dout  in  64  FIFO rd_dout
- fifo_vld  in  1  FIFO rd_out_vld
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in any state except IDLE
- frame_cnt  out  CNT_W  completed frames, wraps
- late_vld_err  out  1  sticky: fifo_vld seen outside WAIT

Behaviour:
- Clock and reset: one clock, rd_clk. Reset is synchronous, active-low on rst_n, sampled at the rd_clk edge.
- Reset values: state IDLE; fifo_rd_en=0, tx_valid=0, tx_data=0, busy=0, frame_cnt=0, late_vld_err=0, word register=0, checksum=0.
- Reset mid-frame: the word in flight is discarded, and no further tx_valid occurs until a new frame starts.
- All outputs are registered.
- State machine: IDLE, REQ, WAIT, HDR0, HDR1, DATA, CSUM.
- IDLE: if pack_en=1, go to REQ next cycle.
- REQ: fifo_rd_en=1 for exactly this one cycle. Load timeout counter with 0, then go to WAIT.
- WAIT:
  - fifo_vld=1: capture fifo_dout into the word register, clear the checksum, go to HDR0.
  - Else, when the counter reaches RD_TIMEOUT-1: go to IDLE (FIFO treated as empty). This gives a re-poll period of RD_TIMEOUT+2 cycles while pack_en=1 and the FIFO is empty.
- HDR0/HDR1/DATA/CSUM transfer rule:
  - tx_valid=1 with stable tx_data until the cycle tx_valid&tx_ready.
  - The next byte is presented the following cycle, so tx_valid may stay high back to back.
  - tx_data and tx_valid must not change while tx_valid=1 and tx_ready=0.
- Byte order: HDR0, then HDR1, then data bytes word[63:56] down to word[7:0] (3-bit byte index), then CSUM.
- Checksum = XOR of the 8 data bytes only; header bytes are excluded.
- On the CSUM transfer: frame_cnt increments (wrapping 2^CNT_W-1 to 0) and the state returns to IDLE. Minimum gap between frames is IDLE+REQ+1 WAIT cycle.
- pack_en is sampled only in IDLE. Deasserting it mid-frame completes the current frame, then the block stays in IDLE.
- fifo_vld in any state except WAIT: data ignored, late_vld_err set to 1 and held until reset.
- fifo_vld on the same cycle the timeout expires: vld wins and the word is captured.
- Only one fifo_rd_en pulse is outstanding at a time, so no FIFO word is ever requested without a capture window.
- busy = (state != IDLE).

Test Plan:
- Single word, ready always high: FIFO holds 0x0123456789ABCDEF and pack_en=1 → one fifo_rd_en pulse; tx bytes A5 5A 01 23 45 67 89 AB CD EF 00 on 11 consecutive cycles; frame_cnt 0→1; busy low after the frame.
- Backpressure: word 0xFF00000000000001, tx_ready toggling 1-0-0-1 pattern → tx_data held stable while not ready; byte sequence A5 5A FF 00 00 00 00 00 00 01 FE; no byte dropped or duplicated.
- Empty FIFO: pack_en=1, fifo_vld never asserted → fifo_rd_en pulses every 6 cycles (RD_TIMEOUT=4); tx_valid stays 0; frame_cnt unchanged; late_vld_err=0.
- pack_en dropped during the DATA state of the 1st frame, FIFO holding 2 words → the 1st frame completes with 11 bytes; no 2nd fifo_rd_en; frame_cnt=1; busy=0.
- Spurious fifo_vld during HDR1 → late_vld_err=1 and stays 1; the frame in progress is unaffected.
- rst_n low for one cycle during DATA byte 4 → the next cycle shows tx_valid=0, frame_cnt=0, state IDLE. With frame_cnt preset near wrap (CNT_W=4, 16 frames), a separate run shows frame_cnt wraps 15→0.
